// File: rtl/ext_pkg.sv
// Shared definitions for the immediate encoder path.
// Holds the extender opcode values, the encoder FSM state encoding and the
// classification result record produced by imm_classify.
package ext_pkg;

  localparam logic [1:0] EOP_SIGN = 2'b00;
  localparam logic [1:0] EOP_ZERO = 2'b01;
  localparam logic [1:0] EOP_LUI  = 2'b10;
  localparam logic [1:0] EOP_RSVD = 2'b11;

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StOne   = 2'd1,
    StHi    = 2'd2,
    StLo    = 2'd3
  } enc_state_e;

  typedef struct packed {
    logic        is_split;
    logic [1:0]  eop;
    logic [15:0] imm_first;
    logic [15:0] imm_low;
  } imm_class_t;

endpackage

// File: rtl/imm_encoder_if.sv
// Streaming bus of the immediate encoder.
// in_*  : 32-bit constants towards the encoder (valid/ready).
// out_* : imm/EOp beats from the encoder (valid/ready), plus last/split flags.
// slave modport is the encoder side, master modport is the producer/consumer side.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_imm;
  logic [1:0]  out_eop;
  logic        out_last;
  logic        out_split;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_imm, out_eop, out_last, out_split
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_imm, out_eop, out_last, out_split
  );
endinterface

// File: rtl/imm_classify.sv
// Combinational classifier: decides how a 32-bit constant is expressed as
// imm/EOp beats.
// value_i : constant to classify
// class_o : {is_split, eop of the first beat, imm of the first beat, low half}
module imm_classify
  import ext_pkg::*;
(
  input  logic [31:0] value_i,
  output imm_class_t  class_o
);

  logic sign_fit;
  logic zero_fit;
  logic lui_fit;

  // Bits 31..15 all equal means the sign-extended 16-bit form reproduces it.
  assign sign_fit = (&value_i[31:15]) | ~(|value_i[31:15]);
  assign zero_fit = ~(|value_i[31:16]);
  assign lui_fit  = ~(|value_i[15:0]);

  always_comb begin
    class_o          = '0;
    class_o.imm_low  = value_i[15:0];
    if (sign_fit) begin
      class_o.eop       = EOP_SIGN;
      class_o.imm_first = value_i[15:0];
    end else if (zero_fit) begin
      class_o.eop       = EOP_ZERO;
      class_o.imm_first = value_i[15:0];
    end else if (lui_fit) begin
      class_o.eop       = EOP_LUI;
      class_o.imm_first = value_i[31:16];
    end else begin
      class_o.is_split  = 1'b1;
      class_o.eop       = EOP_LUI;
      class_o.imm_first = value_i[31:16];
    end
  end

endmodule

// File: rtl/imm_encoder.sv
// Streaming immediate encoder: turns 32-bit constants into the imm/EOp beats
// that the immediate extender expands back to the same value. Constants that
// fit no single form go out as an upper (lui) beat then a lower (ori) beat.
// clk       : clock, rising edge
// reset     : synchronous active-high reset
// bus       : in/out valid-ready streams (slave side)
// cnt_words : constants accepted (wraps)
// cnt_split : accepted constants that needed two beats (wraps)
module imm_encoder
  import ext_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  imm_encoder_if.slave     bus,
  output logic [CNT_W-1:0] cnt_words,
  output logic [CNT_W-1:0] cnt_split
);

  enc_state_e       state_q;
  logic [15:0]      imm_q;
  logic [1:0]       eop_q;
  logic             last_q;
  logic             split_q;
  logic [15:0]      low_q;
  logic [CNT_W-1:0] words_q;
  logic [CNT_W-1:0] splits_q;

  imm_class_t cls;
  logic       in_ready;
  logic       in_fire;

  imm_classify u_classify (
    .value_i (bus.in_data),
    .class_o (cls)
  );

  // Held off during reset so nothing is accepted in that cycle.
  assign in_ready = ~reset & ((state_q == StEmpty) |
                              (((state_q == StOne) | (state_q == StLo)) & bus.out_ready));
  assign in_fire  = bus.in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StEmpty;
      imm_q    <= '0;
      eop_q    <= EOP_SIGN;
      last_q   <= 1'b0;
      split_q  <= 1'b0;
      low_q    <= '0;
      words_q  <= '0;
      splits_q <= '0;
    end else begin
      if (in_fire) begin
        words_q <= words_q + CNT_W'(1);
        if (cls.is_split) begin
          splits_q <= splits_q + CNT_W'(1);
        end
      end

      unique case (state_q)
        StHi: begin
          if (bus.out_ready) begin
            state_q <= StLo;
            imm_q   <= low_q;
            eop_q   <= EOP_ZERO;
            last_q  <= 1'b1;
          end
        end
        default: begin
          // StEmpty, StOne, StLo: in_fire here implies the held beat (if any)
          // is being consumed in the same cycle.
          if (in_fire) begin
            imm_q   <= cls.imm_first;
            eop_q   <= cls.eop;
            split_q <= cls.is_split;
            if (cls.is_split) begin
              state_q <= StHi;
              last_q  <= 1'b0;
              low_q   <= cls.imm_low;
            end else begin
              state_q <= StOne;
              last_q  <= 1'b1;
            end
          end else if ((state_q != StEmpty) && bus.out_ready) begin
            state_q <= StEmpty;
          end
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q != StEmpty);
  assign bus.out_imm   = imm_q;
  assign bus.out_eop   = eop_q;
  assign bus.out_last  = last_q;
  assign bus.out_split = split_q;
  assign cnt_words     = words_q;
  assign cnt_split     = splits_q;

endmodule

// File: tb/tb_imm_encoder.sv
module tb_imm_encoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imm_encoder_if b ();
  imm_encoder_if w ();

  logic [15:0] cnt_words;
  logic [15:0] cnt_split;
  logic [1:0]  w_words;
  logic [1:0]  w_split;

  imm_encoder #(.CNT_W(16)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (b),
    .cnt_words (cnt_words),
    .cnt_split (cnt_split)
  );

  imm_encoder #(.CNT_W(2)) u_dut_w (
    .clk       (clk),
    .reset     (reset),
    .bus       (w),
    .cnt_words (w_words),
    .cnt_split (w_split)
  );

  // {valid, imm, eop, last, split}
  logic [20:0] obs;
  logic [20:0] wobs;
  assign obs  = {b.out_valid, b.out_imm, b.out_eop, b.out_last, b.out_split};
  assign wobs = {w.out_valid, w.out_imm, w.out_eop, w.out_last, w.out_split};

  int total = 0;
  int bad   = 0;

  task automatic test_reset();
    reset = 1'b1;
    b.in_valid = 1'b1; b.in_data = 32'h0000_1234; b.out_ready = 1'b1;
    @(negedge clk); #1;
    total++;
    if (b.in_ready !== 1'b0) begin
      bad++; $display("FAIL reset_in_ready got=%b want=0", b.in_ready);
    end
    @(negedge clk); #1;
    total++;
    if (obs !== 21'h0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", obs);
    end
    total++;
    if (cnt_words !== 16'd0 || cnt_split !== 16'd0) begin
      bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", cnt_words, cnt_split);
    end
    b.in_valid = 1'b0;
    reset = 1'b0;
  endtask

  task automatic test_single();
    @(negedge clk);
    b.in_valid = 1'b1; b.in_data = 32'h0000_1234; b.out_ready = 1'b1;
    #1;
    total++;
    if (b.in_ready !== 1'b1) begin
      bad++; $display("FAIL single_in_ready got=%b want=1", b.in_ready);
    end
    @(negedge clk);
    b.in_valid = 1'b0;
    #1;
    total++;
    if (obs !== {1'b1, 16'h1234, 2'b00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL single_beat got=%h want=%h", obs, {1'b1, 16'h1234, 2'b00, 2'b10});
    end
    total++;
    if (cnt_words !== 16'd1) begin
      bad++; $display("FAIL single_cnt_words got=%0d want=1", cnt_words);
    end
    @(negedge clk); #1;
    total++;
    if (b.out_valid !== 1'b0) begin
      bad++; $display("FAIL single_drain got=%b want=0", b.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vin [3];
    logic [20:0] exp [3];
    vin[0] = 32'hFFFF_8000; exp[0] = {1'b1, 16'h8000, 2'b00, 1'b1, 1'b0};
    vin[1] = 32'h0000_8000; exp[1] = {1'b1, 16'h8000, 2'b01, 1'b1, 1'b0};
    vin[2] = 32'hABCD_0000; exp[2] = {1'b1, 16'hABCD, 2'b10, 1'b1, 1'b0};
    b.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b.in_valid = (i < 3);
      if (i < 3) b.in_data = vin[i];
      #1;
      if (i < 3) begin
        total++;
        if (b.in_ready !== 1'b1) begin
          bad++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, b.in_ready);
        end
      end
      if (i > 0) begin
        total++;
        if (obs !== exp[i-1]) begin
          bad++; $display("FAIL b2b_beat[%0d] got=%h want=%h", i - 1, obs, exp[i-1]);
        end
      end
    end
    total++;
    if (cnt_split !== 16'd0 || cnt_words !== 16'd4) begin
      bad++; $display("FAIL b2b_counters got=%0d/%0d want=4/0", cnt_words, cnt_split);
    end
  endtask

  task automatic test_split();
    @(negedge clk);
    b.in_valid = 1'b1; b.in_data = 32'h1234_5678; b.out_ready = 1'b1;
    @(negedge clk);
    b.in_data = 32'h0000_0001;  // offered while busy; must not be taken
    #1;
    total++;
    if (obs !== {1'b1, 16'h1234, 2'b10, 1'b0, 1'b1}) begin
      bad++; $display("FAIL split_hi got=%h want=%h", obs, {1'b1, 16'h1234, 2'b10, 2'b01});
    end
    total++;
    if (b.in_ready !== 1'b0) begin
      bad++; $display("FAIL split_in_ready got=%b want=0", b.in_ready);
    end
    @(negedge clk);
    b.in_valid = 1'b0;
    #1;
    total++;
    if (obs !== {1'b1, 16'h5678, 2'b01, 1'b1, 1'b1}) begin
      bad++; $display("FAIL split_lo got=%h want=%h", obs, {1'b1, 16'h5678, 2'b01, 2'b11});
    end
    total++;
    if (cnt_split !== 16'd1 || cnt_words !== 16'd5) begin
      bad++; $display("FAIL split_counters got=%0d/%0d want=5/1", cnt_words, cnt_split);
    end
    @(negedge clk); #1;
    total++;
    if (b.out_valid !== 1'b0) begin
      bad++; $display("FAIL split_drain got=%b want=0", b.out_valid);
    end
  endtask

  task automatic test_stall();
    @(negedge clk);
    b.in_valid = 1'b1; b.in_data = 32'h1234_5678; b.out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      b.in_valid  = 1'b0;
      b.out_ready = (i == 4);
      #1;
      total++;
      if (obs !== {1'b1, 16'h1234, 2'b10, 1'b0, 1'b1} || b.in_ready !== 1'b0) begin
        bad++; $display("FAIL stall_hold[%0d] got=%h rdy=%b want=%h rdy=0", i, obs,
                        b.in_ready, {1'b1, 16'h1234, 2'b10, 2'b01});
      end
    end
    @(negedge clk); #1;
    total++;
    if (obs !== {1'b1, 16'h5678, 2'b01, 1'b1, 1'b1} || b.in_ready !== 1'b1) begin
      bad++; $display("FAIL stall_lo got=%h rdy=%b want=%h rdy=1", obs, b.in_ready,
                      {1'b1, 16'h5678, 2'b01, 2'b11});
    end
    @(negedge clk); #1;
    total++;
    if (b.out_valid !== 1'b0 || cnt_words !== 16'd6 || cnt_split !== 16'd2) begin
      bad++; $display("FAIL stall_drain got=v%b %0d/%0d want=v0 6/2", b.out_valid,
                      cnt_words, cnt_split);
    end
  endtask

  task automatic test_reset_mid_split();
    @(negedge clk);
    b.in_valid = 1'b1; b.in_data = 32'h1234_5678; b.out_ready = 1'b0;
    @(negedge clk);
    b.in_valid = 1'b0;
    reset = 1'b1;
    #1;
    total++;
    if (b.out_valid !== 1'b1 || cnt_words !== 16'd7) begin
      bad++; $display("FAIL mid_pre got=v%b words=%0d want=v1 words=7", b.out_valid, cnt_words);
    end
    @(negedge clk);
    reset = 1'b0;
    b.out_ready = 1'b1;
    #1;
    total++;
    if (obs !== 21'h0 || cnt_words !== 16'd0 || cnt_split !== 16'd0) begin
      bad++; $display("FAIL mid_reset got=%h %0d/%0d want=0 0/0", obs, cnt_words, cnt_split);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      total++;
      if (b.out_valid !== 1'b0) begin
        bad++; $display("FAIL mid_no_low[%0d] got=%b want=0", i, b.out_valid);
      end
    end
  endtask

  task automatic test_wrap();
    w.out_ready = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      w.in_valid = 1'b1;
      w.in_data  = 32'(i);
      #1;
      total++;
      if (w.in_ready !== 1'b1) begin
        bad++; $display("FAIL wrap_in_ready[%0d] got=%b want=1", i, w.in_ready);
      end
    end
    @(negedge clk);
    w.in_valid = 1'b0;
    #1;
    total++;
    if (w_words !== 2'd1 || w_split !== 2'd0) begin
      bad++; $display("FAIL wrap_counters got=%0d/%0d want=1/0", w_words, w_split);
    end
    total++;
    if (wobs !== {1'b1, 16'h0005, 2'b00, 1'b1, 1'b0}) begin
      bad++; $display("FAIL wrap_last_beat got=%h want=%h", wobs, {1'b1, 16'h0005, 2'b00, 2'b10});
    end
  endtask

  initial begin
    reset = 1'b1;
    b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b0;
    w.in_valid = 1'b0; w.in_data = '0; w.out_ready = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_split();
    test_stall();
    test_reset_mid_split();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
Streaming inverse of the immediate extender. It takes 32-bit constants and produces the 16-bit imm / 2-bit EOp pairs that the extender expands back to the same value. A constant that fits no single form is split into two beats, a lui-style upper half followed by an ori-style lower half. The block sits in the instruction-generation / test-vector path ahead of the datapath. It uses valid/ready handshakes on both sides and keeps per-class counters.

Parameters:
CNT_W, 16, width of the statistics counters (wrap-around)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  in_data is valid
in_ready  output  1  block accepts in_data this cycle
in_data  input  32  constant to encode
out_valid  output  1  out_imm/out_eop/out_last valid
out_ready  input  1  consumer takes the current beat
out_imm  output  16  immediate field
out_eop  output  2  extender opcode: 00 sign, 01 zero, 10 upper (lui); 11 never emitted
out_last  output  1  1 on the final beat for a constant
out_split  output  1  1 on both beats of a two-beat constant
cnt_words  output  CNT_W  constants accepted
cnt_split  output  CNT_W  constants needing two beats

Behaviour:
- Input handshake: a transfer happens when in_valid && in_ready. Output handshake: a beat completes when out_valid && out_ready.
- Classification of value v, first match wins:
  - v[31:15] all equal: EOp 00, imm = v[15:0], single beat.
  - v[31:16] == 0: EOp 01, imm = v[15:0], single beat.
  - v[15:0] == 0: EOp 10, imm = v[31:16], single beat.
  - Otherwise split: beat 1 = {v[31:16], EOp 10, last 0}; beat 2 = {v[15:0], EOp 01, last 1}.
- v = 0 and other values that match several rules take the earliest rule (EOp 00).
- FSM states:
  - EMPTY: out_valid = 0.
  - ONE: single beat held.
  - HI: upper beat held; low half saved internally.
  - LO: lower beat held.
- Transitions:
  - On an input transfer, go to ONE or HI by classification.
  - HI with out_ready goes to LO; out_imm takes the saved low half, out_eop = 01, out_last = 1.
  - ONE or LO with out_ready: go to ONE or HI if a new input transfers in the same cycle, else EMPTY.
- in_ready = (state == EMPTY) || ((state == ONE || state == LO) && out_ready). in_ready is 0 in HI.
- Latency: a constant accepted at edge N has its first beat valid after edge N, with a registered output and no combinational in-to-out path. Back-to-back single-beat constants sustain 1 per cycle. A split constant costs 2 cycles.
- While out_valid && !out_ready, out_imm / out_eop / out_last / out_split are held stable.
- Counters:
  - cnt_words increments on every input transfer.
  - cnt_split increments on an input transfer whose value classifies as split.
  - Both wrap from 2^CNT_W-1 to 0.
- Reset, including mid-split: state EMPTY, out_valid = 0, out_imm = 0, out_eop = 0, out_last = 0, out_split = 0, both counters 0, saved low half 0. A pending low beat is discarded.
- in_ready is 0 during the reset cycle. in_valid is ignored while reset = 1.

Decomposition:
- Shared package (ext_pkg) holds:
  - EOp constants EOP_SIGN = 2'b00, EOP_ZERO = 2'b01, EOP_LUI = 2'b10, EOP_RSVD = 2'b11.
  - FSM state encoding.
- Sub-module imm_classify is natural: purely combinational, 32-bit in, produces {is_split, eop, imm_first, imm_low}, and is reusable by the bench as a model.
- The top holds the FSM, output registers and counters.

Test Plan:
- Reset then in_data 0x00001234 with out_ready = 1: next cycle out = {imm 0x1234, eop 00, last 1, split 0}; cnt_words = 1.
- Stream 0xFFFF8000, 0x00008000, 0xABCD0000 back-to-back with out_ready = 1: in_ready stays 1; outputs {8000,00}, {8000,01}, {ABCD,10}; cnt_split = 0.
- 0x12345678: beat {1234,10,last 0,split 1}, then {5678,01,last 1,split 1}; in_ready = 0 during the first beat; cnt_split = 1.
- out_ready held 0 for 3 cycles on a split: outputs stable, in_ready = 0; then release, and both beats drain in order.
- Assert reset while in HI for 0x12345678: next cycle out_valid = 0, counters 0, no low beat is ever emitted.
- CNT_W = 2: accept 5 constants; cnt_words reads 1 (wraps).
